// File: rtl/ped_crossing_scheduler_if.sv
// Bundle between the pedestrian scheduler and its surroundings.
// The buttons and controller status flow in; requests, pending flags and counters flow out.
// The master drives the buttons and controller status. The slave is the scheduler.
interface ped_crossing_scheduler_if #(
  parameter int CNT_W = 8
);
  logic             btn_A;
  logic             btn_B;
  logic [2:0]       system_state;
  logic [6:0]       countdown;
  logic             ped_req_A;
  logic             ped_req_B;
  logic             pending_A;
  logic             pending_B;
  logic [CNT_W-1:0] served_A;
  logic [CNT_W-1:0] served_B;
  logic             busy;

  modport master (
    output btn_A, btn_B, system_state, countdown,
    input  ped_req_A, ped_req_B, pending_A, pending_B, served_A, served_B, busy
  );

  modport slave (
    input  btn_A, btn_B, system_state, countdown,
    output ped_req_A, ped_req_B, pending_A, pending_B, served_A, served_B, busy
  );
endinterface

// File: rtl/ped_crossing_scheduler.sv
// Purpose: latches pedestrian presses and forwards one at a time to the light controller while green.
// Latency: press -> pending after 1 edge; pending+eligible -> ped_req after 1 more edge; all outputs registered.
// Backpressure: requests wait in pending until their road is green with enough countdown and the FSM is idle.
module ped_crossing_scheduler #(
  parameter int MIN_REMAIN  = 10,
  parameter int HOLD_CYCLES = 4,
  parameter int ACK_TIMEOUT = 127,
  parameter int COOLDOWN    = 30,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ped_crossing_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, COOL} state_e;

  localparam logic [2:0] A_GREEN   = 3'b000;
  localparam logic [2:0] B_GREEN   = 3'b010;
  localparam logic [6:0] MIN_R     = 7'(MIN_REMAIN);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] ACK_LAST  = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] COOL_LAST = 8'(COOLDOWN - 1);

  state_e           state_q, state_d;
  logic             sel_q, sel_d;          // 0 = road A, 1 = road B
  logic [7:0]       cnt_q, cnt_d;          // cycles spent in the current state
  logic             btn_a_q, btn_b_q;
  logic             pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic [CNT_W-1:0] srv_a_q, srv_a_d, srv_b_q, srv_b_d;
  logic             press_a, press_b, elig_a, elig_b, ack_clr;
  logic [2:0]       sel_green;

  assign press_a   = bus.btn_A & ~btn_a_q;
  assign press_b   = bus.btn_B & ~btn_b_q;
  // The two green codes differ, so at most one road can be eligible.
  assign elig_a    = pend_a_q && (bus.system_state == A_GREEN) && (bus.countdown > MIN_R);
  assign elig_b    = pend_b_q && (bus.system_state == B_GREEN) && (bus.countdown > MIN_R);
  assign sel_green = sel_q ? B_GREEN : A_GREEN;

  // Next-state logic: pick an eligible road, hold the pulse, wait for the controller, cool down.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    ack_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (elig_a || elig_b) begin
          state_d = ISSUE;
          sel_d   = elig_b;
          cnt_d   = 8'd0;
        end
      end
      ISSUE: begin
        // Pulse width is fixed; controller state changes here are ignored.
        if (cnt_q == HOLD_LAST) begin
          state_d = WAIT_ACK;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_ACK: begin
        if (bus.system_state != sel_green) begin
          ack_clr = 1'b1;
          cnt_d   = 8'd0;
          if (COOLDOWN == 0) state_d = IDLE;
          else               state_d = COOL;
        end else if (cnt_q == ACK_LAST) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      COOL: begin
        if (cnt_q == COOL_LAST) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Pending and served updates; a fresh press beats an ack-clear on the same road.
  always_comb begin
    pend_a_d = press_a | (pend_a_q & ~(ack_clr & ~sel_q));
    pend_b_d = press_b | (pend_b_q & ~(ack_clr &  sel_q));
    srv_a_d  = srv_a_q;
    srv_b_d  = srv_b_q;
    if (ack_clr && !sel_q && (srv_a_q != '1)) srv_a_d = srv_a_q + CNT_W'(1);
    if (ack_clr &&  sel_q && (srv_b_q != '1)) srv_b_d = srv_b_q + CNT_W'(1);
  end

  // State, button samples, pending flags and counters; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      cnt_q    <= 8'd0;
      btn_a_q  <= 1'b0;
      btn_b_q  <= 1'b0;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      srv_a_q  <= '0;
      srv_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      btn_a_q  <= bus.btn_A;
      btn_b_q  <= bus.btn_B;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      srv_a_q  <= srv_a_d;
      srv_b_q  <= srv_b_d;
    end
  end

  // Outputs are pure decodes of registered state.
  assign bus.ped_req_A = (state_q == ISSUE) && !sel_q;
  assign bus.ped_req_B = (state_q == ISSUE) &&  sel_q;
  assign bus.pending_A = pend_a_q;
  assign bus.pending_B = pend_b_q;
  assign bus.served_A  = srv_a_q;
  assign bus.served_B  = srv_b_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ped_crossing_scheduler.sv
// Bench for ped_crossing_scheduler: directed scenarios followed by randomized traffic.
// A reference model predicts per-cycle outputs and request pulses into queues.
// A negedge monitor pops those queues and compares them against the DUT.
module tb_ped_crossing_scheduler;
  localparam int MIN_REMAIN = 10;
  localparam int HOLD       = 4;
  localparam int ACK_TO     = 127;
  localparam int COOL       = 30;
  localparam int CNT_W      = 8;
  localparam int SRV_MAX    = (1 << CNT_W) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_ISSUE = 1;
  localparam int M_WAIT  = 2;
  localparam int M_COOL  = 3;

  typedef struct packed {
    logic             req_a;
    logic             req_b;
    logic             pend_a;
    logic             pend_b;
    logic             busy;
    logic [CNT_W-1:0] srv_a;
    logic [CNT_W-1:0] srv_b;
  } snap_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ped_crossing_scheduler_if #(.CNT_W(CNT_W)) bus ();

  ped_crossing_scheduler #(
    .MIN_REMAIN (MIN_REMAIN),
    .HOLD_CYCLES(HOLD),
    .ACK_TIMEOUT(ACK_TO),
    .COOLDOWN   (COOL),
    .CNT_W      (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int    checks = 0;
  int    fails  = 0;
  snap_t snap_q[$];
  int    txn_q[$];

  // Reference model: requests queue per road, one crossing is served at a time.
  int phase, left, sel;
  bit pend [2];
  bit prevb[2];
  int served[2];

  function automatic logic [2:0] green(int r);
    return (r == 1) ? 3'b010 : 3'b000;
  endfunction

  function automatic void model_reset();
    phase = M_IDLE;
    left  = 0;
    sel   = 0;
    for (int r = 0; r < 2; r++) begin
      pend[r]   = 1'b0;
      prevb[r]  = 1'b0;
      served[r] = 0;
    end
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.req_a  = (phase == M_ISSUE) && (sel == 0);
    s.req_b  = (phase == M_ISSUE) && (sel == 1);
    s.pend_a = pend[0];
    s.pend_b = pend[1];
    s.busy   = (phase != M_IDLE);
    s.srv_a  = CNT_W'(served[0]);
    s.srv_b  = CNT_W'(served[1]);
    return s;
  endfunction

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Advance the model one clock and queue what the DUT should show afterwards.
  always @(posedge clk) begin : model_step
    bit btn[2];
    bit press[2];
    bit clr[2];
    if (!rst_n) begin
      model_reset();
    end else begin
      btn[0] = bus.btn_A;
      btn[1] = bus.btn_B;
      for (int r = 0; r < 2; r++) begin
        press[r] = btn[r] && !prevb[r];
        prevb[r] = btn[r];
        clr[r]   = 1'b0;
      end
      case (phase)
        M_IDLE: begin
          for (int r = 0; r < 2; r++) begin
            if (phase == M_IDLE && pend[r] && bus.system_state == green(r) &&
                int'(bus.countdown) > MIN_REMAIN) begin
              phase = M_ISSUE;
              left  = HOLD;
              sel   = r;
              txn_q.push_back(r);
            end
          end
        end
        M_ISSUE: begin
          left--;
          if (left == 0) begin
            phase = M_WAIT;
            left  = ACK_TO;
          end
        end
        M_WAIT: begin
          if (bus.system_state != green(sel)) begin
            clr[sel] = 1'b1;
            if (served[sel] < SRV_MAX) served[sel]++;
            phase = (COOL == 0) ? M_IDLE : M_COOL;
            left  = COOL;
          end else begin
            left--;
            if (left == 0) phase = M_IDLE;
          end
        end
        default: begin
          left--;
          if (left == 0) phase = M_IDLE;
        end
      endcase
      for (int r = 0; r < 2; r++) pend[r] = press[r] || (pend[r] && !clr[r]);
    end
    snap_q.push_back(model_snap());
  end

  // Asynchronous reset invalidates whatever was predicted for the current cycle.
  always @(negedge rst_n) begin
    model_reset();
    if (snap_q.size() > 0) snap_q[snap_q.size() - 1] = '0;
    txn_q.delete();
  end

  // Monitor: compare every cycle's outputs and every request pulse start.
  logic prev_ra = 1'b0;
  logic prev_rb = 1'b0;
  always @(negedge clk) begin : monitor
    snap_t got, exp;
    int    road, want;
    got = {bus.ped_req_A, bus.ped_req_B, bus.pending_A, bus.pending_B, bus.busy,
           bus.served_A, bus.served_B};
    if (snap_q.size() > 0) begin
      exp = snap_q.pop_front();
      checks++;
      if (got !== exp) begin
        fails++;
        $display("FAIL outputs at %0t: got req=%b%b pend=%b%b busy=%b srvA=%0d srvB=%0d, expected req=%b%b pend=%b%b busy=%b srvA=%0d srvB=%0d",
                 $time, got.req_a, got.req_b, got.pend_a, got.pend_b, got.busy, got.srv_a, got.srv_b,
                 exp.req_a, exp.req_b, exp.pend_a, exp.pend_b, exp.busy, exp.srv_a, exp.srv_b);
      end
    end
    if ((bus.ped_req_A && !prev_ra) || (bus.ped_req_B && !prev_rb)) begin
      road = (bus.ped_req_A && bus.ped_req_B) ? 2 : (bus.ped_req_B ? 1 : 0);
      if (txn_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL request_pulse at %0t: got road %0d, expected no request", $time, road);
      end else begin
        want = txn_q.pop_front();
        check("request_road", road, want);
      end
    end
    prev_ra = bus.ped_req_A;
    prev_rb = bus.ped_req_B;
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ctl(logic [2:0] st, logic [6:0] cd);
    bus.system_state = st;
    bus.countdown    = cd;
  endtask

  initial begin
    bus.btn_A = 1'b0;
    bus.btn_B = 1'b0;
    set_ctl(3'b000, 7'd50);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Basic A request, acked by A yellow, then cooldown.
    bus.btn_A = 1'b1; tick(1);
    bus.btn_A = 1'b0; tick(7);
    set_ctl(3'b001, 7'd20); tick(40);

    // B pressed during A green waits for B green.
    set_ctl(3'b000, 7'd50);
    bus.btn_B = 1'b1; tick(1);
    bus.btn_B = 1'b0; tick(10);
    set_ctl(3'b010, 7'd80); tick(10);
    set_ctl(3'b011, 7'd20); tick(40);

    // Countdown at the threshold blocks issue; pending survives to the next B green.
    set_ctl(3'b010, 7'd10);
    bus.btn_B = 1'b1; tick(1);
    bus.btn_B = 1'b0; tick(10);
    set_ctl(3'b011, 7'd5);  tick(5);
    set_ctl(3'b000, 7'd50); tick(5);
    set_ctl(3'b010, 7'd60); tick(10);
    set_ctl(3'b011, 7'd20); tick(40);

    // Repeated presses coalesce into one request.
    set_ctl(3'b010, 7'd90);
    for (int i = 0; i < 5; i++) begin
      bus.btn_B = 1'b1; tick(4);
      bus.btn_B = 1'b0; tick(4);
    end
    set_ctl(3'b011, 7'd20); tick(40);

    // Controller never acts: timeout, then re-issue while still eligible.
    set_ctl(3'b000, 7'd50);
    bus.btn_A = 1'b1; tick(1);
    bus.btn_A = 1'b0; tick(150);
    set_ctl(3'b001, 7'd20); tick(40);

    // Reset during the second ISSUE cycle clears outputs immediately.
    set_ctl(3'b000, 7'd50);
    bus.btn_A = 1'b1; tick(1);
    bus.btn_A = 1'b0; tick(2);
    rst_n = 1'b0;
    #1;
    check("async_reset_ped_req_A", int'(bus.ped_req_A), 0);
    check("async_reset_pending_A", int'(bus.pending_A), 0);
    check("async_reset_busy",      int'(bus.busy),      0);
    check("async_reset_served_A",  int'(bus.served_A),  0);
    tick(2);
    rst_n = 1'b1;
    tick(3);

    // Randomized traffic with occasional long holds and rare resets.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, (c < 2000) ? 29 : 149) == 0) begin
        if ($urandom_range(0, 9) == 0) bus.system_state = 3'($urandom_range(4, 7));
        else                           bus.system_state = 3'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 1) == 1) bus.countdown = 7'($urandom_range(5, 15));
      else                           bus.countdown = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) bus.btn_A = ~bus.btn_A;
      if ($urandom_range(0, 7) == 0) bus.btn_B = ~bus.btn_B;
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
      end
      tick(1);
    end

    // Drain: no green, so every outstanding request acks and the FSM settles.
    bus.btn_A = 1'b0;
    bus.btn_B = 1'b0;
    set_ctl(3'b001, 7'd20);
    tick(200);
    check("drain_busy", int'(bus.busy), 0);
    @(negedge clk);
    #1;
    check("drain_request_queue", txn_q.size(), 0);
    check("drain_output_queue",  snap_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ped_crossing_scheduler.md
# ped_crossing_scheduler

Sits between the raw pedestrian buttons and `traffic_light_system` and decides when each crossing request is passed on. Latches button presses per road and holds them as pending. Forwards a request to the light controller only while that road is green with enough countdown left. Waits for the controller to act, then counts the served request and enforces a cooldown before the next one.

## Interface
- `MIN_REMAIN`, 10: countdown must be strictly greater than this for a request to be forwarded.
- `HOLD_CYCLES`, 4: width in cycles of the forwarded request pulse (1..15).
- `ACK_TIMEOUT`, 127: maximum cycles spent waiting for the controller to act (1..255).
- `COOLDOWN`, 30: idle cycles enforced after each served request (0..255).
- `CNT_W`, 8: width of the served counters.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_A` in 1: raw button for road A, level, synchronous to `clk`.
- `btn_B` in 1: raw button for road B, level, synchronous to `clk`.
- `system_state` in 3: controller state. 000 is A green, 001 A yellow, 010 B green, 011 B yellow.
- `countdown` in 7: controller remaining time, unsigned.
- `ped_req_A` out 1: request to controller input `ped_button_A`.
- `ped_req_B` out 1: request to controller input `ped_button_B`.
- `pending_A` out 1: road A has an unserved request.
- `pending_B` out 1: road B has an unserved request.
- `served_A` out CNT_W: count of acknowledged A requests, saturating.
- `served_B` out CNT_W: count of acknowledged B requests, saturating.
- `busy` out 1: FSM is not in IDLE.

## Operation
- **Edge detect.** Each button is sampled into a one-bit register. A press is a cycle where `btn_X`=1 and the previous sample was 0.
  - A press sets `pending_X`.
  - Held levels and repeated presses while pending coalesce into one request.
- **Eligibility.** Road X is eligible when all of the following hold:
  - `pending_X`=1.
  - `system_state` is X-green (A: 000, B: 010).
  - `countdown` > `MIN_REMAIN`.
  - Only one road can be eligible in any cycle.
- **FSM states.** IDLE, ISSUE, WAIT_ACK, COOL.
  - **IDLE → ISSUE** when some road is eligible. That road is latched as `sel`.
  - **ISSUE:** `ped_req_sel`=1 for exactly `HOLD_CYCLES` cycles, then → WAIT_ACK. The other `ped_req` stays 0.
  - **WAIT_ACK → COOL** (ack) when `system_state` ≠ the sel-green code:
    - `pending_sel` is cleared.
    - `served_sel` is incremented, saturating at all-ones.
  - **WAIT_ACK → IDLE** (timeout) after `ACK_TIMEOUT` cycles with no ack. `pending_sel` is kept and no count is made.
  - **COOL → IDLE** after `COOLDOWN` cycles. COOLDOWN=0 goes directly to IDLE on ack.
- **Pending during activity.** Presses keep setting pending in every state.
- **Set vs clear collision.** If a press on road sel lands in the same cycle as its ack-clear, set wins and `pending_sel` stays 1.
- **Ack during ISSUE.** A state change during ISSUE does not abort the pulse. The ack is evaluated from the first WAIT_ACK cycle.
- **Reset.** Asserting `rst_n` low at any point, including mid-ISSUE, immediately drives:
  - FSM to IDLE.
  - All outputs to 0.
  - Button samples to 0.
  - All internal counters to 0.

## Timing
- Reset values: `ped_req_A`=0, `ped_req_B`=0, `pending_A`=0, `pending_B`=0, `served_A`=0, `served_B`=0, `busy`=0.
- Every output is registered. No combinational path runs from any input to any output.
- Press at edge n (`btn` high, previous sample low) gives `pending` high after edge n.
- With the road eligible, `ped_req` rises after edge n+1 and `busy` rises on the same edge.
- `ped_req` is high for exactly `HOLD_CYCLES` consecutive cycles.
- Ack sampled at edge m gives `pending` clear and `served` incremented after edge m. `busy` remains 1 through COOL.
- Timeout: after `ACK_TIMEOUT` consecutive WAIT_ACK cycles, the FSM is in IDLE on the next edge.
- The eligibility check uses the current cycle's `system_state` and `countdown`. It is not re-checked once in ISSUE.

## Test plan
- **Basic A request.** Reset, state=000, countdown=50, one-cycle press on `btn_A`.
  - `pending_A` 1 after the next edge.
  - `ped_req_A` high for 4 cycles.
  - State moves to 001, then `served_A`=1 and `pending_A`=0.
  - `busy` drops 30 cycles later.
- **Wait for eligibility.** Press `btn_B` while state=000.
  - No `ped_req_B` while state=000.
  - When state=010 and countdown=80, `ped_req_B` pulses for 4 cycles.
  - `ped_req_A` stays 0 throughout.
- **Low countdown.** State=010, countdown=10, `pending_B`=1.
  - No issue while countdown ≤ 10.
  - Issue never occurs if the state leaves 010 first; `pending_B` persists to the next B green.
- **Coalescing.** Five presses on `btn_B`, 4 cycles high and 4 low each, during B green with countdown=90.
  - Exactly one 4-cycle `ped_req_B` pulse.
  - `served_B` increments by 1 after ack.
- **Timeout.** State held at 000 after ISSUE.
  - FSM returns to IDLE 127 cycles into WAIT_ACK.
  - `pending_A` stays 1 and `served_A` is unchanged.
  - Re-issues once eligible.
- **Reset mid-operation.** `rst_n` pulsed low during the 2nd ISSUE cycle.
  - `ped_req_A`, `pending_A` and `busy` go to 0 immediately, asynchronously.
  - No served count is made.
